// File: rtl/i2c_slave_transmitter.sv
`default_nettype none
// =============================================================================
// Module   : i2c_slave_transmitter
// Brief    : Read-only I2C slave that answers its address and streams bytes out.
// Revision : 1.0 - initial release
// =============================================================================
module i2c_slave_transmitter #(
  parameter logic [6:0] ADDRESS = 7'b1100110
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  inout  wire        io_sda,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_busy,
  output logic       o_nack,
  output logic       o_underrun
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_TX_BYTE   = 3'd3,
    ST_RX_ACK    = 3'd4,
    ST_WAIT_STOP = 3'd5
  } state_t;

  logic       r_scl_ff1, r_scl_ff2, r_scl_prev;
  logic       r_sda_ff1, r_sda_ff2, r_sda_prev;

  state_t     r_state, w_state_next;
  logic [3:0] r_bit_cnt, w_bit_cnt_next;
  logic [6:0] r_addr_shift, w_addr_shift_next;
  logic [7:0] r_tx_shift, w_tx_shift_next;
  logic       r_sda_oe, w_sda_oe_next;
  logic       r_phase, w_phase_next;
  logic       r_tx_ready, w_tx_ready_next;
  logic       r_nack, w_nack_next;
  logic       r_underrun, w_underrun_next;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic       w_load;
  logic [7:0] w_tx_byte;

  // Synchronizers preset high so a reset bus reads as idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scl_ff1  <= 1'b1;
      r_scl_ff2  <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_ff1  <= 1'b1;
      r_sda_ff2  <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_ff1  <= i_scl;
      r_scl_ff2  <= r_scl_ff1;
      r_scl_prev <= r_scl_ff2;
      r_sda_ff1  <= io_sda;
      r_sda_ff2  <= r_sda_ff1;
      r_sda_prev <= r_sda_ff2;
    end
  end

  assign w_scl_rise = r_scl_ff2 & ~r_scl_prev;
  assign w_scl_fall = ~r_scl_ff2 & r_scl_prev;
  assign w_start    = r_sda_prev & ~r_sda_ff2 & r_scl_ff2 & r_scl_prev;
  assign w_stop     = ~r_sda_prev & r_sda_ff2 & r_scl_ff2 & r_scl_prev;

  assign w_tx_byte  = i_tx_valid ? i_tx_data : 8'hFF;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '1;
      r_addr_shift <= '1;
      r_tx_shift   <= '1;
      r_sda_oe     <= 1'b0;
      r_phase      <= 1'b0;
      r_tx_ready   <= 1'b0;
      r_nack       <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_bit_cnt    <= w_bit_cnt_next;
      r_addr_shift <= w_addr_shift_next;
      r_tx_shift   <= w_tx_shift_next;
      r_sda_oe     <= w_sda_oe_next;
      r_phase      <= w_phase_next;
      r_tx_ready   <= w_tx_ready_next;
      r_nack       <= w_nack_next;
      r_underrun   <= w_underrun_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_bit_cnt_next    = r_bit_cnt;
    w_addr_shift_next = r_addr_shift;
    w_tx_shift_next   = r_tx_shift;
    w_sda_oe_next     = r_sda_oe;
    w_phase_next      = r_phase;
    w_tx_ready_next   = 1'b0;
    w_nack_next       = 1'b0;
    w_underrun_next   = 1'b0;
    w_load            = 1'b0;

    if (w_start) begin
      w_state_next   = ST_ADDR;
      w_bit_cnt_next = 4'd0;
      w_sda_oe_next  = 1'b0;
      w_phase_next   = 1'b0;
    end else if (w_stop) begin
      w_state_next  = ST_IDLE;
      w_sda_oe_next = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR: begin
          if (w_scl_rise) begin
            w_bit_cnt_next = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              // Eighth bit is R/W; only a read of our own address is answered.
              if ((r_addr_shift == ADDRESS) && r_sda_ff2) begin
                w_state_next = ST_ADDR_ACK;
                w_phase_next = 1'b0;
              end else begin
                w_state_next = ST_WAIT_STOP;
              end
              w_sda_oe_next = 1'b0;
            end else begin
              w_addr_shift_next = {r_addr_shift[5:0], r_sda_ff2};
            end
          end
        end

        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_phase_next  = 1'b1;
              w_sda_oe_next = 1'b1;
            end else begin
              w_load = 1'b1;
            end
          end
        end

        ST_TX_BYTE: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == 4'd7) begin
              w_state_next  = ST_RX_ACK;
              w_sda_oe_next = 1'b0;
              w_phase_next  = 1'b0;
            end else begin
              w_tx_shift_next = {r_tx_shift[6:0], r_tx_shift[7]};
              w_sda_oe_next   = ~r_tx_shift[6];
              w_bit_cnt_next  = r_bit_cnt + 4'd1;
            end
          end
        end

        ST_RX_ACK: begin
          if (w_scl_rise) begin
            if (r_sda_ff2) begin
              w_nack_next  = 1'b1;
              w_state_next = ST_WAIT_STOP;
            end else begin
              w_phase_next = 1'b1;
            end
          end else if (w_scl_fall && r_phase) begin
            w_load = 1'b1;
          end
        end

        default: begin
        end
      endcase

      // Byte load happens on the SCL falling edge that ends an ACK slot.
      if (w_load) begin
        w_state_next    = ST_TX_BYTE;
        w_bit_cnt_next  = 4'd0;
        w_tx_shift_next = w_tx_byte;
        w_sda_oe_next   = ~w_tx_byte[7];
        w_tx_ready_next = i_tx_valid;
        w_underrun_next = ~i_tx_valid;
      end
    end
  end

  assign io_sda     = r_sda_oe ? 1'b0 : 1'bz;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_tx_ready = r_tx_ready;
  assign o_nack     = r_nack;
  assign o_underrun = r_underrun;

endmodule
`default_nettype wire

// File: doc/i2c_slave_transmitter.md
I2C_SLAVE_TRANSMITTER -- requirements
Module: i2c_slave_transmitter

Interface
REQ-001 SHALL have parameter ADDRESS, default 7'b1100110, giving the 7-bit slave address.
REQ-002 SHALL have port i_clk, input, 1, system clock; all state is updated on its rising edge.
REQ-003 SHALL have port i_rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port i_scl, input, 1, I2C clock from the bus; this block never drives it.
REQ-005 SHALL have port io_sda, inout, 1, I2C data; the block drives 1'b0 or 'bz and never drives 1'b1.
REQ-006 SHALL have port i_tx_data, input, 8, the next byte to transmit.
REQ-007 SHALL have port i_tx_valid, input, 1, meaning i_tx_data is valid.
REQ-008 SHALL have port o_tx_ready, output, 1, a one-cycle pulse when i_tx_data is consumed.
REQ-009 SHALL have port o_busy, output, 1, high whenever the state is not IDLE.
REQ-010 SHALL have port o_nack, output, 1, a one-cycle pulse when the master NACKs a data byte.
REQ-011 SHALL have port o_underrun, output, 1, a one-cycle pulse when a byte is loaded while i_tx_valid is low.

Function
REQ-012 SHALL pass i_scl and io_sda through 2-flop synchronizers, then detect edges on the synchronized values.
- Edge-to-action latency is at most 4 i_clk cycles.
- Requirement on the master: SCL high and low phases are each at least 8 i_clk cycles.
REQ-013 SHALL detect START as an SDA falling edge while SCL is high, and STOP as an SDA rising edge while SCL is high.
REQ-014 SHALL implement states IDLE, ADDR, ADDR_ACK, TX_BYTE, RX_ACK and WAIT_STOP.
REQ-015 SHALL, on START or repeated START in any state, clear the bit counter and enter ADDR.
REQ-016 SHALL, on STOP in any state, enter IDLE with SDA released.
REQ-017 SHALL, in ADDR, shift 8 bits MSB-first on SCL rising edges: 7 address bits, then R/W.
REQ-018 SHALL, after the 8th bit:
- if address equals ADDRESS and R/W=1: enter ADDR_ACK;
- otherwise: enter WAIT_STOP with SDA released and no ACK.
REQ-019 SHALL, in ADDR_ACK, drive SDA low from the first SCL falling edge through the next SCL falling edge.
REQ-020 SHALL load the transmit shift register on entering TX_BYTE:
- if i_tx_valid=1: load i_tx_data and pulse o_tx_ready;
- if i_tx_valid=0: load 8'hFF and pulse o_underrun.
REQ-021 SHALL, in TX_BYTE, present bits MSB-first, changing SDA only after SCL falling edges.
- A 0 bit drives SDA low; a 1 bit releases SDA.
- After the 8th bit's SCL falling edge, enter RX_ACK.
REQ-022 SHALL, in RX_ACK, release SDA and sample it on the SCL rising edge:
- 0 (ACK): return to TX_BYTE at the next SCL falling edge;
- 1 (NACK): pulse o_nack and enter WAIT_STOP.
REQ-023 SHALL, in WAIT_STOP, keep SDA released and ignore SCL until START or STOP.
REQ-024 SHALL give START/STOP detection priority over any coincident SCL edge in the same cycle.
REQ-025 SHALL never change SDA while synchronized SCL is high, except to release it on STOP, START or reset.
REQ-026 SHALL keep o_tx_ready, o_nack and o_underrun mutually exclusive, each exactly one cycle wide.

Reset
REQ-027 SHALL, while i_rst=1, immediately (asynchronously) set:
- state to IDLE;
- io_sda to 'bz;
- o_busy, o_tx_ready, o_nack and o_underrun to 0;
- shift registers, bit counter and synchronizers to 1's, so SCL and SDA read as idle-high.
REQ-028 SHALL, after reset deassertion mid-transfer, ignore bus traffic until the next START.

Verification
REQ-029 SHALL be checked with a read of address 0x66 with R/W=1, i_tx_data=8'hE3, i_tx_valid=1:
- slave ACKs the 9th clock;
- SDA carries 1,1,1,0,0,0,1,1;
- one o_tx_ready pulse;
- master NACK gives one o_nack pulse;
- STOP drops o_busy.
REQ-030 SHALL be checked with address 0x65 and R/W=1: SDA is never driven low, and o_busy stays high until STOP, then 0.
REQ-031 SHALL be checked with address 0x66 and R/W=0 (the write direction): no ACK, and state is WAIT_STOP until STOP.
REQ-032 SHALL be checked with a two-byte read of 8'hA5 then 8'h3C, master ACK then NACK:
- SDA shows both bytes;
- exactly two o_tx_ready pulses;
- one o_nack pulse.
REQ-033 SHALL be checked with i_tx_valid=0 at the byte load: 8'hFF is sent, o_underrun pulses once, and o_tx_ready stays 0.
REQ-034 SHALL be checked with i_rst pulsed during the 3rd data bit while SDA is driven low:
- io_sda is 'bz in the same cycle;
- o_busy is 0;
- the next START plus 0x66/R=1 transaction completes normally.
